// File: rtl/cpu_core_mc.sv
`default_nettype none
// ============================================================================
// Module      : cpu_core_mc
// Description : Multi-cycle successor to the single-cycle 8-bit cpu. Executes
//               ALU/branch ops in one clock and load/store ops through a
//               data-memory port that stalls the core while BUSYWAIT is high.
//               Instruction format: OP[31:24] RD[23:16] RS1[15:8] RS2/IMM[7:0].
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_core_mc #(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [31:0]       PC,
  input  logic [31:0]       INSTRUCTION,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [DATA_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              BUSYWAIT,
  output logic              RETIRED
);

  localparam int RA_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  localparam logic [7:0] c_op_loadi = 8'h00;
  localparam logic [7:0] c_op_mov   = 8'h01;
  localparam logic [7:0] c_op_add   = 8'h02;
  localparam logic [7:0] c_op_sub   = 8'h03;
  localparam logic [7:0] c_op_and   = 8'h04;
  localparam logic [7:0] c_op_or    = 8'h05;
  localparam logic [7:0] c_op_j     = 8'h06;
  localparam logic [7:0] c_op_beq   = 8'h07;
  localparam logic [7:0] c_op_lwd   = 8'h08;
  localparam logic [7:0] c_op_lwi   = 8'h09;
  localparam logic [7:0] c_op_swd   = 8'h0A;
  localparam logic [7:0] c_op_swi   = 8'h0B;
  localparam logic [7:0] c_op_bne   = 8'h0C;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // State and registered outputs
  state_t            r_state, w_state_nxt;
  logic [31:0]       r_pc, w_pc_nxt;
  logic              r_mem_read, w_mem_read_nxt;
  logic              r_mem_write, w_mem_write_nxt;
  logic [DATA_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_retired, w_retired_nxt;
  logic [RA_W-1:0]   r_ld_rd, w_ld_rd_nxt;
  logic [DATA_W-1:0] r_regs [REG_COUNT];

  // Decode
  logic [7:0]        w_op;
  logic [RA_W-1:0]   w_rd, w_rs1, w_rs2;
  logic [DATA_W-1:0] w_rs1_val, w_rs2_val, w_imm;
  logic [31:0]       w_br_off, w_pc_seq, w_pc_br;
  logic              w_unused_rs1_hi;

  // Execute
  logic              w_alu_we;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_taken;
  logic              w_mem_op;
  logic              w_mem_ld;
  logic [DATA_W-1:0] w_mem_ea;

  // Register-file write port
  logic              w_rf_we;
  logic [RA_W-1:0]   w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;

  assign w_op      = INSTRUCTION[31:24];
  assign w_rd      = INSTRUCTION[16 +: RA_W];
  assign w_rs1     = INSTRUCTION[8 +: RA_W];
  assign w_rs2     = INSTRUCTION[0 +: RA_W];
  assign w_rs1_val = r_regs[w_rs1];
  assign w_rs2_val = r_regs[w_rs2];

  // Upper RS1 byte bits are don't-care once the register index is taken
  assign w_unused_rs1_hi = ^INSTRUCTION[15:8];

  generate
    if (DATA_W > 8) begin : g_sext_wide
      assign w_imm = {{(DATA_W-8){INSTRUCTION[7]}}, INSTRUCTION[7:0]};
    end else begin : g_sext_none
      assign w_imm = INSTRUCTION[7:0];
    end
  endgenerate

  // Branch offset counts words relative to the following instruction
  assign w_br_off = {{22{INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
  assign w_pc_seq = r_pc + 32'd4;
  assign w_pc_br  = w_pc_seq + w_br_off;

  // Opcode decode: ALU result, branch decision, memory access classification
  always_comb begin
    w_alu_we  = 1'b0;
    w_alu_res = '0;
    w_taken   = 1'b0;
    w_mem_op  = 1'b0;
    w_mem_ld  = 1'b0;
    w_mem_ea  = w_imm;
    case (w_op)
      c_op_loadi: begin w_alu_we = 1'b1; w_alu_res = w_imm; end
      c_op_mov:   begin w_alu_we = 1'b1; w_alu_res = w_rs2_val; end
      c_op_add:   begin w_alu_we = 1'b1; w_alu_res = w_rs1_val + w_rs2_val; end
      c_op_sub:   begin w_alu_we = 1'b1; w_alu_res = w_rs1_val - w_rs2_val; end
      c_op_and:   begin w_alu_we = 1'b1; w_alu_res = w_rs1_val & w_rs2_val; end
      c_op_or:    begin w_alu_we = 1'b1; w_alu_res = w_rs1_val | w_rs2_val; end
      c_op_j:     w_taken = 1'b1;
      c_op_beq:   w_taken = (w_rs1_val == w_rs2_val);
      c_op_bne:   w_taken = (w_rs1_val != w_rs2_val);
      c_op_lwd:   begin w_mem_op = 1'b1; w_mem_ld = 1'b1; w_mem_ea = w_rs2_val; end
      c_op_lwi:   begin w_mem_op = 1'b1; w_mem_ld = 1'b1; end
      c_op_swd:   begin w_mem_op = 1'b1; w_mem_ea = w_rs2_val; end
      c_op_swi:   w_mem_op = 1'b1;
      default:    ;
    endcase
  end

  // Next-state and next-output logic; stores and loads park in MEM_WAIT
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_ld_rd_nxt     = r_ld_rd;
    w_retired_nxt   = 1'b0;
    w_rf_we         = 1'b0;
    w_rf_waddr      = w_rd;
    w_rf_wdata      = w_alu_res;
    case (r_state)
      RUN: begin
        if (w_mem_op) begin
          w_mem_read_nxt  = w_mem_ld;
          w_mem_write_nxt = ~w_mem_ld;
          w_mem_addr_nxt  = w_mem_ea;
          w_mem_wdata_nxt = w_rs1_val;
          w_ld_rd_nxt     = w_rd;
          w_state_nxt     = MEM_WAIT;
        end else begin
          w_rf_we       = w_alu_we;
          w_pc_nxt      = w_taken ? w_pc_br : w_pc_seq;
          w_retired_nxt = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Destination comes from the captured rd, not the live instruction
        if (!BUSYWAIT) begin
          w_rf_we         = r_mem_read;
          w_rf_waddr      = r_ld_rd;
          w_rf_wdata      = MEM_RDATA;
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_pc_nxt        = w_pc_seq;
          w_retired_nxt   = 1'b1;
          w_state_nxt     = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // State register and registered memory-port outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= RUN;
      r_pc        <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_retired   <= 1'b0;
      r_ld_rd     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_retired   <= w_retired_nxt;
      r_ld_rd     <= w_ld_rd_nxt;
    end
  end

  // Register file: cleared on reset, single write port
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_rf_we) begin
      r_regs[w_rf_waddr] <= w_rf_wdata;
    end
  end

  assign PC        = r_pc;
  assign MEM_READ  = r_mem_read;
  assign MEM_WRITE = r_mem_write;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WDATA = r_mem_wdata;
  assign RETIRED   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_cpu_core_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_core_mc
// Description : Self-checking bench for cpu_core_mc. An instruction-set level
//               model (register array, PC, data-memory array) predicts PC,
//               memory-port traffic and retirement for directed and random
//               instruction streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_core_mc;

  logic        CLK;
  logic        RESET;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [7:0]  MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA;
  logic        BUSYWAIT;
  logic        RETIRED;

  cpu_core_mc #(.DATA_W(8), .REG_COUNT(8)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .INSTRUCTION (INSTRUCTION),
    .MEM_READ    (MEM_READ),
    .MEM_WRITE   (MEM_WRITE),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_WDATA   (MEM_WDATA),
    .MEM_RDATA   (MEM_RDATA),
    .BUSYWAIT    (BUSYWAIT),
    .RETIRED     (RETIRED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural reference state
  logic [7:0]  m_regs [8];
  logic [31:0] m_pc;
  logic [7:0]  m_dmem [256];

  // Observations of the last memory instruction
  int g_strobe_cycles;
  int g_retire_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] a,
                                     input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_pc = 32'h0;
  endtask

  // Entered and left at a negative clock edge
  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_pc", PC, 32'h0);
    check_eq("rst_mem_read", MEM_READ, 1'b0);
    check_eq("rst_mem_write", MEM_WRITE, 1'b0);
    check_eq("rst_mem_addr", MEM_ADDR, 8'h00);
    check_eq("rst_mem_wdata", MEM_WDATA, 8'h00);
    check_eq("rst_retired", RETIRED, 1'b0);
    RESET = 1'b0;
    model_reset();
  endtask

  // Executes one instruction with 'busy' stall cycles on memory ops.
  // Entered and left at a negative clock edge.
  task automatic exec_instr(input logic [31:0] ins, input int busy);
    logic [7:0]         op, imm, addr, wd, a, b;
    int                 rd, rs1, rs2, left;
    logic               mem, ld;
    logic [31:0]        npc;
    logic signed [31:0] off;

    op  = ins[31:24];
    rd  = int'(ins[18:16]);
    rs1 = int'(ins[10:8]);
    rs2 = int'(ins[2:0]);
    imm = ins[7:0];
    a   = m_regs[rs1];
    b   = m_regs[rs2];
    off = $signed(ins[23:16]);
    npc = m_pc + 32'd4;
    mem = 1'b0; ld = 1'b0; addr = 8'h00; wd = 8'h00;

    case (op)
      8'h00: m_regs[rd] = imm;
      8'h01: m_regs[rd] = b;
      8'h02: m_regs[rd] = a + b;
      8'h03: m_regs[rd] = a - b;
      8'h04: m_regs[rd] = a & b;
      8'h05: m_regs[rd] = a | b;
      8'h06: npc = m_pc + 32'd4 + off * 4;
      8'h07: if (a == b) npc = m_pc + 32'd4 + off * 4;
      8'h0C: if (a != b) npc = m_pc + 32'd4 + off * 4;
      8'h08: begin mem = 1'b1; ld = 1'b1; addr = b;   end
      8'h09: begin mem = 1'b1; ld = 1'b1; addr = imm; end
      8'h0A: begin mem = 1'b1; addr = b;   wd = a; end
      8'h0B: begin mem = 1'b1; addr = imm; wd = a; end
      default: ;
    endcase

    INSTRUCTION = ins;
    BUSYWAIT    = 1'($urandom);
    MEM_RDATA   = 8'($urandom);
    @(posedge CLK);
    @(negedge CLK);

    if (!mem) begin
      check_eq("alu_retired", RETIRED, 1'b1);
      check_eq("alu_pc", PC, npc);
      check_eq("alu_strobes", {MEM_READ, MEM_WRITE}, 2'b00);
      m_pc = npc;
    end else begin
      g_strobe_cycles = 0;
      g_retire_cnt    = 0;
      left = busy;
      while (1) begin
        check_eq("wait_read", MEM_READ, ld);
        check_eq("wait_write", MEM_WRITE, !ld);
        check_eq("wait_addr", MEM_ADDR, addr);
        if (!ld) check_eq("wait_wdata", MEM_WDATA, wd);
        check_eq("wait_pc", PC, m_pc);
        check_eq("wait_retired", RETIRED, 1'b0);
        if (MEM_READ || MEM_WRITE) g_strobe_cycles++;
        if (RETIRED) g_retire_cnt++;
        if (left == 0) break;
        left--;
        BUSYWAIT    = 1'b1;
        MEM_RDATA   = 8'($urandom);
        INSTRUCTION = $urandom;
        @(posedge CLK);
        @(negedge CLK);
      end
      BUSYWAIT    = 1'b0;
      MEM_RDATA   = ld ? m_dmem[addr] : 8'($urandom);
      INSTRUCTION = $urandom;
      @(posedge CLK);
      @(negedge CLK);
      check_eq("rel_retired", RETIRED, 1'b1);
      check_eq("rel_strobes", {MEM_READ, MEM_WRITE}, 2'b00);
      check_eq("rel_pc", PC, m_pc + 32'd4);
      if (RETIRED) g_retire_cnt++;
      if (ld) m_regs[rd] = m_dmem[addr];
      else    m_dmem[addr] = wd;
      m_pc = m_pc + 32'd4;
      INSTRUCTION = mk(8'hFF, 8'h00, 8'h00, 8'h00);
    end
  endtask

  task automatic run_random(input int count);
    logic [7:0] ops [15];
    logic [7:0] op;
    ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
            8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hFF};
    for (int n = 0; n < count; n++) begin
      op = ops[$urandom_range(0, 14)];
      exec_instr(mk(op, 8'($urandom), 8'($urandom), 8'($urandom)),
                 int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    RESET       = 1'b1;
    INSTRUCTION = 32'hFF00_0000;
    BUSYWAIT    = 1'b0;
    MEM_RDATA   = 8'h00;
    for (int i = 0; i < 256; i++) m_dmem[i] = 8'($urandom);
    @(negedge CLK);
    do_reset();

    // Wrap-around add and sequential PC
    exec_instr(mk(8'h00, 8'h01, 8'h00, 8'h05), 0);
    check_eq("pc_after_loadi1", PC, 32'h4);
    exec_instr(mk(8'h00, 8'h02, 8'h00, 8'hFB), 0);
    check_eq("pc_after_loadi2", PC, 32'h8);
    exec_instr(mk(8'h02, 8'h03, 8'h01, 8'h02), 0);
    check_eq("pc_after_add", PC, 32'hC);
    exec_instr(mk(8'h0B, 8'h00, 8'h03, 8'h30), 0);
    check_eq("add_wrap_r3", MEM_WDATA, 8'h00);

    // Branch to self holds PC; BNE on equal operands falls through
    exec_instr(mk(8'h07, 8'hFF, 8'h01, 8'h01), 0);
    check_eq("beq_self_pc", PC, 32'h10);
    exec_instr(mk(8'h07, 8'hFF, 8'h01, 8'h01), 0);
    check_eq("beq_self_pc2", PC, 32'h10);
    exec_instr(mk(8'h0C, 8'hFF, 8'h01, 8'h01), 0);
    check_eq("bne_equal_pc", PC, 32'h14);

    // Stalled store: strobe held four cycles, one retirement
    exec_instr(mk(8'h0B, 8'h00, 8'h01, 8'h20), 3);
    check_eq("swi_strobe_cycles", g_strobe_cycles, 32'd4);
    check_eq("swi_retire_cnt", g_retire_cnt, 32'd1);

    // Zero-wait register-indirect load
    m_dmem[8'h20] = 8'hA5;
    exec_instr(mk(8'h00, 8'h02, 8'h00, 8'h20), 0);
    exec_instr(mk(8'h08, 8'h04, 8'h00, 8'h02), 0);
    check_eq("lwd_strobe_cycles", g_strobe_cycles, 32'd1);
    exec_instr(mk(8'h0B, 8'h00, 8'h04, 8'h41), 0);
    check_eq("lwd_r4", MEM_WDATA, 8'hA5);

    run_random(300);

    // Reset mid-program clears every register
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exec_instr(mk(8'h0B, 8'h00, 8'(i), 8'(8'h50 + i)), 0);
    end

    // Reset while a load waits: access aborted, no register write
    exec_instr(mk(8'h00, 8'h02, 8'h00, 8'h33), 0);
    exec_instr(mk(8'h00, 8'h04, 8'h00, 8'h77), 0);
    INSTRUCTION = mk(8'h08, 8'h04, 8'h00, 8'h02);
    BUSYWAIT    = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_eq("abort_read_pending", MEM_READ, 1'b1);
    RESET     = 1'b1;
    BUSYWAIT  = 1'b0;
    MEM_RDATA = 8'h5A;
    @(posedge CLK);
    @(negedge CLK);
    check_eq("abort_read_low", MEM_READ, 1'b0);
    check_eq("abort_pc", PC, 32'h0);
    check_eq("abort_retired", RETIRED, 1'b0);
    RESET = 1'b0;
    model_reset();
    exec_instr(mk(8'h0B, 8'h00, 8'h04, 8'h60), 0);
    check_eq("abort_r4", MEM_WDATA, 8'h00);

    run_random(150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
